// File: rtl/ysyx_25060170_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC, FSM encoding.
package ysyx_25060170_ifu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  // True when the address is on a 32-bit instruction boundary.
  function automatic logic pc_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25060170_pc_reg.sv
// Program counter: reset load, +4 advance on decode handshake, redirect override.
module ysyx_25060170_pc_reg
  import ysyx_25060170_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  // Redirect wins over advance so a taken branch never gets a stray +4.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (advance) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: one outstanding fetch, {pc, inst} to decode, redirect squash.
// Optional macro YSYX_25060170_IFU_ALIGN_CHECK_EN halts fetch on a misaligned PC.
module ysyx_25060170_ifu
  import ysyx_25060170_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [XLEN-1:0]   req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [INST_W-1:0] rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   pc_o,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              misalign_o
);

  ifu_state_e        state;
  logic              drop;
  logic [INST_W-1:0] inst_q;
  logic [XLEN-1:0]   pc;
  logic              accept;
  logic              advance;
  logic              req_ok;

  assign accept  = req_valid_o & req_ready_i;
  assign advance = inst_valid_o & inst_ready_i;

  // req_ok judges the PC that S_REQ will hold next; +4 never changes the low bits.
`ifdef YSYX_25060170_IFU_ALIGN_CHECK_EN
  assign req_ok = pc_aligned(redirect_i ? redirect_pc_i : pc);
`else
  assign req_ok = 1'b1;
`endif

  ysyx_25060170_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect_i),
    .redirect_pc (redirect_pc_i),
    .advance     (advance),
    .pc          (pc)
  );

  assign req_addr_o = {pc[XLEN-1:2], 2'b00};
  assign pc_o       = pc;
  assign inst_o     = inst_q;

  // Fetch FSM; request/valid/misalign flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_REQ;
      drop         <= 1'b0;
      inst_q       <= '0;
      req_valid_o  <= 1'b0;
      inst_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
    end else if (redirect_i) begin
      inst_valid_o <= 1'b0;
      // A request already handed to memory must be waited out and its data dropped.
      if ((state == S_REQ && accept) || (state == S_WAIT && !rsp_valid_i)) begin
        state       <= S_WAIT;
        drop        <= 1'b1;
        req_valid_o <= 1'b0;
        misalign_o  <= 1'b0;
      end else begin
        state       <= S_REQ;
        drop        <= 1'b0;
        req_valid_o <= req_ok;
        misalign_o  <= ~req_ok;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (accept) begin
            state       <= S_WAIT;
            req_valid_o <= 1'b0;
            misalign_o  <= 1'b0;
          end else begin
            req_valid_o <= req_ok;
            misalign_o  <= ~req_ok;
          end
        end
        S_WAIT: begin
          if (rsp_valid_i) begin
            if (drop) begin
              drop        <= 1'b0;
              state       <= S_REQ;
              req_valid_o <= req_ok;
              misalign_o  <= ~req_ok;
            end else begin
              inst_q       <= rsp_data_i;
              state        <= S_HOLD;
              inst_valid_o <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (advance) begin
            state        <= S_REQ;
            inst_valid_o <= 1'b0;
            req_valid_o  <= req_ok;
            misalign_o   <= ~req_ok;
          end
        end
        default: begin
          state        <= S_REQ;
          drop         <= 1'b0;
          req_valid_o  <= 1'b0;
          inst_valid_o <= 1'b0;
          misalign_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Directed self-checking bench for ysyx_25060170_ifu.
module tb_ysyx_25060170_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        misalign_o;

  int checks   = 0;
  int failures = 0;
  int accepts  = 0;

  ysyx_25060170_ifu #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_addr_o    (req_addr_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_data_i    (rsp_data_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && req_valid_o && req_ready_i) accepts <= accepts + 1;
  end

  task automatic do_reset();
    rst = 1'b1; req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0;
    inst_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_ready_i = 1'b1; rsp_valid_i = 1'b1; rsp_data_i = 32'hffff_ffff;
    inst_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%h exp=0", req_valid_o); end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL rst_inst_valid got=%h exp=0", inst_valid_o); end
    checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%h exp=0", misalign_o); end
    checks++; if (pc_o !== RST_PC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc_o, RST_PC); end
    checks++; if (inst_o !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst_o); end
    req_ready_i = 1'b0; rsp_valid_i = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (req_valid_o !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%h exp=1", req_valid_o); end
    checks++; if (req_addr_o !== RST_PC) begin failures++; $display("FAIL first_req_addr got=%h exp=%h", req_addr_o, RST_PC); end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL first_inst_valid got=%h exp=0", inst_valid_o); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    req_ready_i = 1'b1; inst_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL basic_wait_req got=%h exp=0", req_valid_o); end
    req_ready_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = 32'h0010_0093;
    @(negedge clk);
    rsp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL basic_inst_valid got=%h exp=1", inst_valid_o); end
    checks++; if (pc_o !== 32'h8000_0000) begin failures++; $display("FAIL basic_pc got=%h exp=80000000", pc_o); end
    checks++; if (inst_o !== 32'h0010_0093) begin failures++; $display("FAIL basic_inst got=%h exp=00100093", inst_o); end
    @(negedge clk);
    inst_ready_i = 1'b0;
    checks++; if (req_valid_o !== 1'b1) begin failures++; $display("FAIL basic_next_req got=%h exp=1", req_valid_o); end
    checks++; if (req_addr_o !== 32'h8000_0004) begin failures++; $display("FAIL basic_next_addr got=%h exp=80000004", req_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL basic_inst_drop got=%h exp=0", inst_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [3];
    data[0] = 32'h0000_0013; data[1] = 32'h0020_8113; data[2] = 32'hfe01_0ee3;
    do_reset();
    inst_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_addr_o !== RST_PC + 32'(4 * i)) begin failures++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, req_addr_o, RST_PC + 32'(4 * i)); end
      req_ready_i = 1'b1;
      @(negedge clk);
      req_ready_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = data[i];
      @(negedge clk);
      rsp_valid_i = 1'b0;
      checks++; if (inst_o !== data[i] || pc_o !== RST_PC + 32'(4 * i) || inst_valid_o !== 1'b1) begin
        failures++; $display("FAIL b2b_out[%0d] got=%h/%h/%h exp=1/%h/%h", i, inst_valid_o, pc_o, inst_o, RST_PC + 32'(4 * i), data[i]);
      end
      @(negedge clk);
    end
    inst_ready_i = 1'b0;
    checks++; if (req_addr_o !== 32'h8000_000c || req_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_final got=%h/%h exp=1/8000000c", req_valid_o, req_addr_o); end
  endtask

  task automatic test_req_stall();
    int acc0;
    do_reset();
    acc0 = accepts;
    repeat (3) begin
      @(negedge clk);
      checks++; if (req_valid_o !== 1'b1 || req_addr_o !== RST_PC) begin failures++; $display("FAIL stall_req got=%h/%h exp=1/%h", req_valid_o, req_addr_o, RST_PC); end
    end
    req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0;
    @(negedge clk);
    checks++; if (accepts !== acc0 + 1) begin failures++; $display("FAIL stall_accepts got=%0d exp=%0d", accepts, acc0 + 1); end
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL stall_wait_req got=%h exp=0", req_valid_o); end
    rsp_valid_i = 1'b1; rsp_data_i = 32'h0000_0513;
    @(negedge clk);
    rsp_valid_i = 1'b0;
    checks++; if (inst_o !== 32'h0000_0513 || pc_o !== RST_PC) begin failures++; $display("FAIL stall_inst got=%h/%h exp=%h/00000513", pc_o, inst_o, RST_PC); end
  endtask

  task automatic test_decode_stall();
    do_reset();
    req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = 32'h1234_5678;
    @(negedge clk);
    rsp_valid_i = 1'b0;
    repeat (4) begin
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h1234_5678 || pc_o !== RST_PC || req_valid_o !== 1'b0) begin
        failures++; $display("FAIL hold_stable got=%h/%h/%h/%h exp=1/12345678/%h/0", inst_valid_o, inst_o, pc_o, req_valid_o, RST_PC);
      end
      @(negedge clk);
    end
    inst_ready_i = 1'b1;
    @(negedge clk);
    inst_ready_i = 1'b0;
    checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0004) begin failures++; $display("FAIL hold_release got=%h/%h exp=1/80000004", req_valid_o, req_addr_o); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || req_valid_o !== 1'b0) begin failures++; $display("FAIL rw_pending got=%h/%h exp=0/0", inst_valid_o, req_valid_o); end
    rsp_valid_i = 1'b1; rsp_data_i = 32'hdead_beef;
    @(negedge clk);
    rsp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL rw_stale_valid got=%h exp=0", inst_valid_o); end
    checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0100) begin failures++; $display("FAIL rw_new_req got=%h/%h exp=1/80000100", req_valid_o, req_addr_o); end
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL rw_stale_late got=%h exp=0", inst_valid_o); end
  endtask

  task automatic test_redirect_req_accept();
    do_reset();
    req_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0300;
    @(negedge clk);
    req_ready_i = 1'b0; redirect_i = 1'b0;
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL rra_wait got=%h exp=0", req_valid_o); end
    rsp_valid_i = 1'b1; rsp_data_i = 32'h0bad_0bad;
    @(negedge clk);
    rsp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0300) begin
      failures++; $display("FAIL rra_new_req got=%h/%h/%h exp=0/1/80000300", inst_valid_o, req_valid_o, req_addr_o);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = 32'h0000_006f;
    @(negedge clk);
    rsp_valid_i = 1'b0; inst_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0040;
    @(negedge clk);
    inst_ready_i = 1'b0; redirect_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL rh_valid got=%h exp=0", inst_valid_o); end
    checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0040) begin failures++; $display("FAIL rh_req got=%h/%h exp=1/80000040", req_valid_o, req_addr_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'hffff_fffc;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'hffff_fffc) begin failures++; $display("FAIL wrap_req got=%h/%h exp=1/fffffffc", req_valid_o, req_addr_o); end
    req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = 32'h0000_0013;
    @(negedge clk);
    rsp_valid_i = 1'b0; inst_ready_i = 1'b1;
    checks++; if (pc_o !== 32'hffff_fffc || inst_o !== 32'h0000_0013) begin failures++; $display("FAIL wrap_hold got=%h/%h exp=fffffffc/00000013", pc_o, inst_o); end
    @(negedge clk);
    inst_ready_i = 1'b0;
    checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h0 || pc_o !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h/%h/%h exp=1/0/0", req_valid_o, req_addr_o, pc_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0800;
    @(negedge clk);
    redirect_i = 1'b0; req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== RST_PC) begin
      failures++; $display("FAIL mid_rst got=%h/%h/%h exp=0/0/%h", req_valid_o, inst_valid_o, pc_o, RST_PC);
    end
    rst = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = 32'hfeed_face;
    @(negedge clk);
    rsp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || req_valid_o !== 1'b1 || req_addr_o !== RST_PC) begin
      failures++; $display("FAIL mid_after got=%h/%h/%h exp=0/1/%h", inst_valid_o, req_valid_o, req_addr_o, RST_PC);
    end
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0) begin failures++; $display("FAIL mid_ignored got=%h/%h exp=0/0", inst_valid_o, inst_o); end
  endtask

  task automatic test_misalign();
    int acc0;
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0102;
    @(negedge clk);
    redirect_i = 1'b0;
`ifdef YSYX_25060170_IFU_ALIGN_CHECK_EN
    checks++; if (req_valid_o !== 1'b0 || misalign_o !== 1'b1) begin failures++; $display("FAIL mis_set got=%h/%h exp=0/1", req_valid_o, misalign_o); end
    acc0 = accepts;
    req_ready_i = 1'b1;
    @(negedge clk); @(negedge clk);
    req_ready_i = 1'b0;
    checks++; if (accepts !== acc0 || misalign_o !== 1'b1) begin failures++; $display("FAIL mis_hold got=%0d/%h exp=%0d/1", accepts, misalign_o, acc0); end
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0200 || misalign_o !== 1'b0) begin
      failures++; $display("FAIL mis_clear got=%h/%h/%h exp=1/80000200/0", req_valid_o, req_addr_o, misalign_o);
    end
`else
    acc0 = accepts;
    checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0100 || misalign_o !== 1'b0) begin
      failures++; $display("FAIL mis_off got=%h/%h/%h exp=1/80000100/0", req_valid_o, req_addr_o, misalign_o);
    end
    req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0;
    checks++; if (accepts !== acc0 + 1) begin failures++; $display("FAIL mis_off_accept got=%0d exp=%0d", accepts, acc0 + 1); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_req_stall();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_req_accept();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_25060170_ifu.md
# ysyx_25060170_ifu

Instruction fetch unit, directly upstream of the decode stage. Owns the PC, fetches one 32-bit instruction at a time from instruction memory over a valid/ready request/response interface, and presents the `{pc, inst}` pair to decode with a valid/ready handshake. Accepts control-flow redirects from execute and discards any in-flight fetch the redirect makes stale.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid_o`  out  1  fetch request valid to instruction memory.
- `req_ready_i`  in  1  memory accepts the request this cycle.
- `req_addr_o`  out  32  fetch byte address.
- `rsp_valid_i`  in  1  instruction memory response valid.
- `rsp_data_i`  in  32  fetched instruction word.
- `inst_valid_o`  out  1  `inst_o`/`pc_o` valid toward decode.
- `inst_ready_i`  in  1  decode consumes the instruction this cycle.
- `inst_o`  out  32  instruction to decode.
- `pc_o`  out  32  PC of `inst_o`.
- `redirect_i`  in  1  redirect from execute (branch/jump taken).
- `redirect_pc_i`  in  32  redirect target.
- `misalign_o`  out  1  PC misaligned, fetch halted (see Configuration).

## Operation
- FSM states: `S_REQ`, `S_WAIT`, `S_HOLD`. One `drop` flag. At most one outstanding request.
- `S_REQ`: `req_valid_o=1`, `req_addr_o=pc`. On `req_ready_i` -> `S_WAIT`. Address and valid stay stable until accepted.
- `S_WAIT`: on `rsp_valid_i`: if `drop`, clear `drop`, discard data, -> `S_REQ`; else latch `rsp_data_i` into `inst_q`, -> `S_HOLD`.
- `S_HOLD`: `inst_valid_o=1`, `inst_o=inst_q`, `pc_o=pc`. On `inst_ready_i`: `pc <= pc + 4` (mod 2^32, wrap 0xFFFF_FFFC -> 0), -> `S_REQ`.
- Redirect has highest priority, any state: `pc <= redirect_pc_i`; `inst_valid_o` deasserts next cycle.
  - In `S_REQ` without `req_ready_i`: -> `S_REQ` (new address next cycle).
  - In `S_REQ` with `req_ready_i` same cycle: old request is in flight -> `S_WAIT`, `drop=1`.
  - In `S_WAIT` without `rsp_valid_i`: stay `S_WAIT`, `drop=1`.
  - In `S_WAIT` with `rsp_valid_i` same cycle: discard response, -> `S_REQ`, `drop=0`.
  - In `S_HOLD` (with or without `inst_ready_i`): held instruction discarded, no `+4`, -> `S_REQ`.
- Memory contract: response no earlier than the cycle after acceptance; `rsp_valid_i` outside `S_WAIT` ignored.

## Timing
- Reset values: `pc=RESET_PC`, state `S_REQ`, `drop=0`, `inst_q=0`; while `rst` high `req_valid_o=0`, `inst_valid_o=0`, `misalign_o=0`, `pc_o=RESET_PC`, `inst_o=0`.
- First request: cycle after `rst` falls, `req_addr_o=RESET_PC`.
- Zero-wait memory, decode always ready: accept at T, response T+1, `inst_valid_o` T+2, next request T+3; 3 cycles per instruction.
- Reset mid-operation: returns to reset state next edge; an outstanding response arriving after reset is ignored (state `S_REQ`).
- All outputs are functions of registered state only; no input-to-output combinational path.

## Configuration
- `YSYX_25060170_IFU_ALIGN_CHECK_EN` defined: in `S_REQ`, if `pc[1:0]!=0`, no request issued, `misalign_o=1`, FSM holds until redirect to an aligned target or reset.
- Undefined: `req_addr_o={pc[31:2],2'b00}`, `misalign_o` tied 0; port always present.

## Structure
- Shared header (alongside the existing register/opcode defines): FSM state encodings, `RESET_PC` default, instruction width.
- One sub-module: `ysyx_25060170_pc_reg` — PC register with reset, `+4` increment, redirect mux.

## Test plan
- Reset release, memory always ready, returns `0x00100093` -> request at `0x8000_0000`, decode sees `pc_o=0x8000_0000`, `inst_o=0x00100093` two cycles after accept; next request `0x8000_0004`.
- `req_ready_i` low 3 cycles -> `req_valid_o` high, `req_addr_o` stable all 3 cycles, single request counted.
- Decode stalls 4 cycles in `S_HOLD` -> `inst_o`/`pc_o` stable, no new request until handshake.
- Redirect to `0x8000_0100` while in `S_WAIT` -> stale response discarded, `inst_valid_o` never high for it, next request `0x8000_0100`.
- Redirect same cycle as `S_HOLD` handshake -> next request `redirect_pc_i`, not `pc+4`.
- With macro, redirect to `0x8000_0102` -> no request, `misalign_o=1`; redirect to `0x8000_0200` clears it and fetches.
